// File: rtl/key_schedule_reverse.sv
// key_schedule_reverse: inverse AES-128 key expansion, emits round keys N..0 one per accepted beat.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign y_o = SBOX[a_i];
endmodule

module key_schedule_reverse #(
    parameter int MAX_ROUND = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_in_i,
    input  logic [3:0]   times_in_i,
    output logic         busy_o,
    output logic         key_valid_o,
    input  logic         key_ready_i,
    output logic [127:0] key_out_o,
    output logic [3:0]   round_out_o,
    output logic         done_o,
    output logic         err_o
);
    typedef enum logic {IDLE, EMIT} state_t;
    localparam logic [3:0] MAX_R = 4'(MAX_ROUND);
    localparam logic [127:0] RCON = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    state_t state_q, state_d;
    logic [127:0] key_q, key_d, prev_key;
    logic [3:0] round_q, round_d;
    logic done_q, done_d, err_q, err_d;
    logic [31:0] p0, p1, p2, p3, rot, sub;
    logic [7:0] rcon;
    assign p3 = key_q[31:0] ^ key_q[63:32];
    assign p2 = key_q[63:32] ^ key_q[95:64];
    assign p1 = key_q[95:64] ^ key_q[127:96];
    assign rot = {p3[23:0], p3[31:24]};
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sub
            aes_sbox u_sbox (.a_i(rot[8*i +: 8]), .y_o(sub[8*i +: 8]));
        end
    endgenerate
    assign rcon = RCON[8*round_q +: 8];
    assign p0 = key_q[127:96] ^ sub ^ {rcon, 24'h0};
    assign prev_key = {p0, p1, p2, p3};
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        round_d = round_q;
        done_d = 1'b0;
        err_d = 1'b0;
        if (state_q == IDLE) begin
            if (start_i && times_in_i > MAX_R) err_d = 1'b1;
            else if (start_i) begin
                state_d = EMIT;
                key_d = key_in_i;
                round_d = times_in_i;
            end
        end else if (key_ready_i) begin
            state_d = round_q == 4'd0 ? IDLE : EMIT;
            done_d = round_q == 4'd0;
            key_d = round_q == 4'd0 ? key_q : prev_key;
            round_d = round_q == 4'd0 ? round_q : round_q - 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q <= '0;
            round_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            round_q <= round_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end
    assign key_valid_o = state_q == EMIT;
    assign busy_o = state_q == EMIT;
    assign key_out_o = key_q;
    assign round_out_o = round_q;
    assign done_o = done_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_key_schedule_reverse.sv
// tb_key_schedule_reverse: table-driven and randomized checks against a forward key-expansion model.
module tb_key_schedule_reverse;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, key_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0] times_in = '0;
    logic busy, key_valid, done, err;
    logic [127:0] key_out;
    logic [3:0] round_out;
    int errors = 0, checks = 0;
    logic [7:0] sbox [256];
    logic [127:0] rk [0:10];
    logic [127:0] got [0:10];
    logic [127:0] got_first;

    key_schedule_reverse #(.MAX_ROUND(10)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .key_in_i(key_in), .times_in_i(times_in),
        .busy_o(busy), .key_valid_o(key_valid), .key_ready_i(key_ready), .key_out_o(key_out),
        .round_out_o(round_out), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] cipher;
        int n;
        int mode;
        bit poke;
        bit err;
        logic [127:0] first, last, r9, r1;
    } vec_t;
    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00, x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int s);
        return 8'((a << s) | (a >> (8 - s)));
    endfunction

    // S-box built from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] cipher);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        for (int j = 0; j < 4; j++) w[j] = cipher[127 - 32*j -: 32];
        for (int j = 4; j < 44; j++) begin
            t = w[j-1];
            if (j % 4 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[j] = w[j-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic walk(input int n, input int mode, input bit poke);
        int idx = 0, cyc = 0;
        bit rdy;
        key_in = rk[n];
        times_in = 4'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (idx <= n && cyc < 200) begin
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            key_ready = rdy;
            start = poke && idx == 3;
            key_in = ~rk[n];
            times_in = 4'd2;
            chk("key_valid", 128'(key_valid), 128'(1));
            chk("busy", 128'(busy), 128'(1));
            chk("done_low", 128'(done), 128'(0));
            chk("err_low", 128'(err), 128'(0));
            chk("round_out", 128'(round_out), 128'(n - idx));
            chk("key_out", key_out, rk[n - idx]);
            if (idx == 0) got_first = key_out;
            got[n - idx] = key_out;
            if (rdy) idx++;
            tick();
            cyc++;
        end
        start = 1'b0;
        key_ready = 1'b0;
        if (cyc >= 200) begin
            checks++;
            errors++;
            $display("FAIL walk_timeout: got %0d beats required %0d", idx, n + 1);
        end
        chk("done_pulse", 128'(done), 128'(1));
        chk("valid_after", 128'(key_valid), 128'(0));
        chk("busy_after", 128'(busy), 128'(0));
        chk("key_hold", key_out, rk[0]);
        chk("round_hold", 128'(round_out), 128'(0));
    endtask

    task automatic err_seq(input logic [127:0] k);
        logic [127:0] prev_key = key_out;
        logic [3:0] prev_round = round_out;
        key_in = k;
        times_in = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 128'(err), 128'(1));
        chk("err_no_valid", 128'(key_valid), 128'(0));
        chk("err_no_busy", 128'(busy), 128'(0));
        chk("err_key_same", key_out, prev_key);
        chk("err_round_same", 128'(round_out), 128'(prev_round));
        tick();
        chk("err_one_cycle", 128'(err), 128'(0));
        chk("err_still_idle", 128'(key_valid), 128'(0));
    endtask

    initial begin
        logic [127:0] fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        logic [127:0] rk9 = 128'hac7766f319fadc2128d12941575c006e;
        logic [127:0] rk1 = 128'ha0fafe1788542cb123a339392a6c7605;
        int cyc;
        vecs[0] = '{fips, 10, 0, 1'b0, 1'b0, rk10, fips, rk9, rk1};
        vecs[1] = '{fips, 10, 1, 1'b0, 1'b0, rk10, fips, rk9, rk1};
        vecs[2] = '{fips, 1, 0, 1'b0, 1'b0, rk1, fips, '0, '0};
        vecs[3] = '{fips, 0, 0, 1'b0, 1'b0, fips, fips, '0, '0};
        vecs[4] = '{fips, 11, 0, 1'b0, 1'b1, '0, '0, '0, '0};
        build_sbox();
        tick();
        tick();
        chk("rst_valid", 128'(key_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_key", key_out, 128'(0));
        chk("rst_round", 128'(round_out), 128'(0));
        rst_n = 1'b1;
        tick();
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].err) err_seq(vecs[v].cipher);
            else begin
                expand(vecs[v].cipher);
                walk(vecs[v].n, vecs[v].mode, vecs[v].poke);
                chk("vec_first", got_first, vecs[v].first);
                chk("vec_last", got[0], vecs[v].last);
                if (vecs[v].n == 10) begin
                    chk("vec_round9", got[9], vecs[v].r9);
                    chk("vec_round1", got[1], vecs[v].r1);
                end
            end
        end
        // start during EMIT must be ignored
        expand(fips);
        walk(10, 0, 1'b1);
        chk("poke_last", got[0], fips);
        // reset aborts a walk at round 5
        key_in = rk[10];
        times_in = 4'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        key_ready = 1'b1;
        cyc = 0;
        while (round_out != 4'd5 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("reached_round5", 128'(round_out), 128'(5));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        key_ready = 1'b0;
        chk("abort_valid", 128'(key_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_key", key_out, 128'(0));
        chk("abort_round", 128'(round_out), 128'(0));
        tick();
        walk(10, 0, 1'b0);
        chk("after_abort_first", got_first, rk10);
        chk("after_abort_round9", got[9], rk9);
        chk("after_abort_last", got[0], fips);
        for (int t = 0; t < 8; t++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            walk($urandom_range(0, 10), 2, t[0]);
        end
        err_seq(128'h0123456789abcdef0123456789abcdef);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_schedule_reverse.md
Name: key_schedule_reverse

Overview:
- Inverse AES-128 key expansion: walks the key schedule backwards, one round key per accepted beat.
- Loads a round key with its round number N and emits round keys N, N-1, …, 0 (round 0 = cipher key).
- Feeds the decryption datapath, which consumes round keys in reverse order.
- Counterpart of the forward key-expansion block: forward derives key i from key i-1; this block derives key i-1 from key i.

Parameters:
- MAX_ROUND, 10, highest legal round number (AES-128).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  load request; sampled only in IDLE.
- key_in  input  128  round key of round times_in, word 0 in bits [127:96].
- times_in  input  4  round number of key_in, 0..MAX_ROUND.
- busy  output  1  high from the cycle after an accepted start until the last beat is accepted.
- key_valid  output  1  key_out/round_out hold a valid beat.
- key_ready  input  1  consumer accepts the beat when key_valid & key_ready.
- key_out  output  128  current round key.
- round_out  output  4  round number of key_out.
- done  output  1  one-cycle pulse after the round-0 beat is accepted.
- err  output  1  one-cycle pulse when start arrives with times_in > MAX_ROUND.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; busy, key_valid, done and err = 0; key_out = 0; round_out = 0.
- Reset has priority over every other event and aborts any sequence in progress. No partial beat survives.
- FSM states: IDLE, EMIT.
- IDLE with start=1 and times_in ≤ MAX_ROUND:
  - Register key_in into key_out and times_in into round_out.
  - Next cycle: state = EMIT, key_valid = 1, busy = 1 (1-cycle latency).
- IDLE with start=1 and times_in > MAX_ROUND: err = 1 for one cycle; state stays IDLE; outputs unchanged.
- start while in EMIT: ignored; no err pulse.
- EMIT, beat not accepted (key_valid & !key_ready): key_out and round_out hold stable.
- EMIT, beat accepted with round_out > 0:
  - Next cycle key_out = previous round key; round_out decrements by 1; key_valid stays 1.
  - Back-to-back acceptance yields one key per cycle.
- EMIT, beat accepted with round_out = 0:
  - Next cycle key_valid = 0, busy = 0, done = 1 for one cycle; state = IDLE.
  - key_out and round_out keep their last values.
  - A new start is honoured in the same cycle that done is high.
- times_in = 0: exactly one beat (key_in itself) is emitted, then done.
- Inverse step, with k0..k3 the 32-bit words of the current key (k0 = MSW):
  - p3 = k3 ^ k2; p2 = k2 ^ k1; p1 = k1 ^ k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[round_out], 24'h0}.
  - RotWord rotates bytes left by one: [a,b,c,d] → [b,c,d,a].
  - SubWord applies the forward AES S-box to each byte (4 instances of the team's forward S-box).
- Rcon indexed by round_out (the round being undone): 1:01, 2:02, 3:04, 4:08, 5:10, 6:20, 7:40, 8:80, 9:1b, 10:36.
- The Rcon lookup is never exercised at round_out = 0; it returns 00 there.
- key_out is registered. There is no combinational path from key_ready or start to any output.

Test Plan:
- Full walk, FIPS-197 A.1: start with times_in=10, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 → 11 consecutive beats.
  - Beat 0: round_out=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Beat 1: round_out=9, key_out=ac7766f319fadc2128d12941575c006e.
  - Beat 9: round_out=1, key_out=a0fafe1788542cb123a339392a6c7605.
  - Beat 10: round_out=0, key_out=2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses 1 cycle after beat 10.
- Backpressure: same stimulus with key_ready toggling 1,0,0,1,… → key_out/round_out stable while stalled; same 11 values in order; no beat skipped or duplicated.
- Short walk: times_in=1, key_in=a0fafe1788542cb123a339392a6c7605 → beats (1, a0fafe…7605) then (0, 2b7e…4f3c); done; busy=0.
- Edge rounds:
  - times_in=0 → single beat equal to key_in, then done.
  - times_in=11 → err pulse, no key_valid, busy stays 0.
- Reset mid-sequence: rst_n=0 for 1 cycle while round_out=5 → next cycle key_valid=0, busy=0, key_out=0, round_out=0. A fresh start afterwards reproduces the full-walk values.
- start while busy: pulse start with a different key at beat 3 → ignored; sequence continues unchanged to round 0.
